// File: rtl/repeat_each_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : repeat_each_n_pkg
// Description : Shared types and helpers for the repeat_each_n interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
package repeat_each_n_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int cnt_width(input int max_n);
        return $clog2(max_n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/repeat_each_n_if.sv
`default_nettype none
// ============================================================================
// Module      : repeat_each_n_if
// Description : Input and output AXI-Stream bundle of the repeat_each_n block.
// Revision    : 1.0 - initial release
// ============================================================================
interface repeat_each_n_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    // Environment side: produces the input stream, consumes the output stream
    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/repeat_each_n.sv
`default_nettype none
// ============================================================================
// Module      : repeat_each_n
// Description : Emits every accepted stream beat n times (hold or zero-stuff),
//               latching n and mode only at packet starts.
// Revision    : 1.0 - initial release
// ============================================================================
module repeat_each_n
    import repeat_each_n_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int MAX_N = 65535,
    localparam int CW    = cnt_width(MAX_N)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [CW-1:0] n,
    input  wire logic          zero_stuff,
    repeat_each_n_if.slave     axis
);

    localparam logic [CW-1:0] c_one = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [CW-1:0]    r_rep_cnt;
    logic [CW-1:0]    r_n_cur;
    logic             r_zs_cur;
    logic             r_sop;

    logic             w_last_rep;
    logic             w_accept;
    logic             w_xfer;

    assign w_last_rep = (r_rep_cnt == r_n_cur);
    assign w_accept   = axis.i_tvalid & axis.i_tready;
    assign w_xfer     = (r_state == ACTIVE) & axis.o_tready;

    // Refill on the final repetition lets back-to-back beats flow without a bubble
    assign axis.i_tready = ~reset & ((r_state == IDLE) | (axis.o_tready & w_last_rep));
    assign axis.o_tvalid = (r_state == ACTIVE);
    assign axis.o_tdata  = (r_zs_cur && (r_rep_cnt != c_one)) ? '0 : r_data;
    assign axis.o_tlast  = r_last & w_last_rep;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_rep_cnt <= c_one;
            r_n_cur   <= c_one;
            r_zs_cur  <= 1'b0;
            r_sop     <= 1'b1;
        end else if (w_accept) begin
            r_state   <= ACTIVE;
            r_data    <= axis.i_tdata;
            r_last    <= axis.i_tlast;
            r_rep_cnt <= c_one;
            r_sop     <= axis.i_tlast;
            // Configuration only changes between packets
            if (r_sop) begin
                r_n_cur  <= (n == '0) ? c_one : n;
                r_zs_cur <= zero_stuff;
            end
        end else if (w_xfer) begin
            if (w_last_rep) begin
                r_state <= IDLE;
            end else begin
                r_rep_cnt <= r_rep_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_repeat_each_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_repeat_each_n
// Description : Directed self-checking bench for repeat_each_n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_repeat_each_n;

    localparam int WIDTH = 32;
    localparam int CW    = 16;

    logic          clk;
    logic          reset;
    logic [CW-1:0] n;
    logic          zero_stuff;

    int checks   = 0;
    int failures = 0;

    logic [32:0] inq[$];
    logic [32:0] outq[$];
    logic [32:0] expq[$];
    int          outcyc[$];
    logic [7:0]  rdy_log;

    repeat_each_n_if #(.WIDTH(WIDTH)) vif ();

    repeat_each_n #(.WIDTH(WIDTH), .MAX_N(65535)) dut (
        .clk        (clk),
        .reset      (reset),
        .n          (n),
        .zero_stuff (zero_stuff),
        .axis       (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called just after a negedge; drives inq, records output transfers
    task automatic run(input int max_cyc, input bit rand_rdy, input int chg_at,
                       input logic [CW-1:0] chg_n);
        int          cyc       = 0;
        int          acc_cnt   = 0;
        bit          stalled   = 1'b0;
        bit          chg_pend  = 1'b0;
        logic [32:0] prev      = '0;
        outq.delete();
        outcyc.delete();
        rdy_log = '0;
        forever begin
            if (chg_pend) begin
                n        = chg_n;
                chg_pend = 1'b0;
            end
            if (inq.size() == 0 && !vif.o_tvalid) break;
            if (cyc >= max_cyc) begin
                check("run_timeout", 64'(cyc), 64'(max_cyc - 1));
                break;
            end
            vif.i_tvalid = (inq.size() > 0);
            if (inq.size() > 0) begin
                vif.i_tlast = inq[0][32];
                vif.i_tdata = inq[0][31:0];
            end
            vif.o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc < 8) rdy_log[cyc] = vif.i_tready;
            if (stalled) begin
                check("stall_valid", 64'(vif.o_tvalid), 64'd1);
                check("stall_beat", 64'({vif.o_tlast, vif.o_tdata}), 64'(prev));
            end
            stalled = vif.o_tvalid && !vif.o_tready;
            prev    = {vif.o_tlast, vif.o_tdata};
            if (vif.o_tvalid && vif.o_tready) begin
                outq.push_back({vif.o_tlast, vif.o_tdata});
                outcyc.push_back(cyc);
            end
            if (vif.i_tvalid && vif.i_tready) begin
                void'(inq.pop_front());
                acc_cnt++;
                if (acc_cnt == chg_at) chg_pend = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        vif.i_tvalid = 1'b0;
        vif.i_tlast  = 1'b0;
    endtask

    task automatic compare_out(input string name);
        check({name, "_count"}, 64'(outq.size()), 64'(expq.size()));
        for (int i = 0; i < outq.size() && i < expq.size(); i++)
            check($sformatf("%s[%0d]", name, i), 64'(outq[i]), 64'(expq[i]));
    endtask

    initial begin
        int          ocnt;
        logic [31:0] d;
        logic        l;

        reset        = 1'b1;
        n            = 16'd1;
        zero_stuff   = 1'b0;
        vif.i_tdata  = '0;
        vif.i_tlast  = 1'b0;
        vif.i_tvalid = 1'b0;
        vif.o_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_o_tvalid", 64'(vif.o_tvalid), 64'd0);
        check("rst_o_tdata", 64'(vif.o_tdata), 64'd0);
        check("rst_o_tlast", 64'(vif.o_tlast), 64'd0);
        check("rst_i_tready", 64'(vif.i_tready), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Hold, n=3
        n = 16'd3;
        inq = '{{1'b0, 32'hAAAA_0001}, {1'b1, 32'hBBBB_0002}};
        expq = '{{1'b0, 32'hAAAA_0001}, {1'b0, 32'hAAAA_0001}, {1'b0, 32'hAAAA_0001},
                 {1'b0, 32'hBBBB_0002}, {1'b0, 32'hBBBB_0002}, {1'b1, 32'hBBBB_0002}};
        run(50, 1'b0, 0, '0);
        compare_out("hold3");
        check("hold3_ready_log", 64'(rdy_log[6:0]), 64'(7'b1001001));

        // Zero-stuff, n=4
        n = 16'd4;
        zero_stuff = 1'b1;
        inq = '{{1'b0, 32'h1234}, {1'b1, 32'h5678}};
        expq = '{{1'b0, 32'h1234}, 33'h0, 33'h0, 33'h0,
                 {1'b0, 32'h5678}, 33'h0, 33'h0, {1'b1, 32'h0}};
        run(50, 1'b0, 0, '0);
        compare_out("zs4");

        // n=0 pass-through
        n = 16'd0;
        zero_stuff = 1'b0;
        inq.delete();
        expq.delete();
        for (int i = 0; i < 16; i++) begin
            d = 32'h1111_1111 * (i + 1);
            l = (i == 15);
            inq.push_back({l, d});
            expq.push_back({l, d});
        end
        run(100, 1'b0, 0, '0);
        compare_out("pass");
        if (outcyc.size() == 16) begin
            check("pass_first_cyc", 64'(outcyc[0]), 64'd1);
            check("pass_last_cyc", 64'(outcyc[15]), 64'd16);
        end else begin
            check("pass_cyc_count", 64'(outcyc.size()), 64'd16);
        end

        // Backpressure, n=2
        n = 16'd2;
        inq.delete();
        expq.delete();
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            l = ((i % 10) == 9);
            inq.push_back({l, d});
            expq.push_back({1'b0, d});
            expq.push_back({l, d});
        end
        run(2000, 1'b1, 0, '0);
        compare_out("bp2");

        // Mid-packet n change: first packet stays at n=2, next at n=5
        n = 16'd2;
        inq = '{{1'b0, 32'hC0}, {1'b0, 32'hC1}, {1'b1, 32'hC2}, {1'b0, 32'hD0}, {1'b1, 32'hD1}};
        expq.delete();
        for (int i = 0; i < 2; i++) expq.push_back({1'b0, 32'hC0});
        for (int i = 0; i < 2; i++) expq.push_back({1'b0, 32'hC1});
        expq.push_back({1'b0, 32'hC2});
        expq.push_back({1'b1, 32'hC2});
        for (int i = 0; i < 5; i++) expq.push_back({1'b0, 32'hD0});
        for (int i = 0; i < 4; i++) expq.push_back({1'b0, 32'hD1});
        expq.push_back({1'b1, 32'hD1});
        run(100, 1'b0, 1, 16'd5);
        compare_out("midchg");

        // Reset mid-repetition, n=8
        n = 16'd8;
        ocnt = 0;
        vif.o_tready = 1'b1;
        vif.i_tvalid = 1'b1;
        vif.i_tlast  = 1'b1;
        vif.i_tdata  = 32'hDEAD_BEEF;
        for (int c = 0; c < 20 && ocnt < 3; c++) begin
            #1;
            if (vif.i_tvalid && vif.i_tready) begin
                @(negedge clk);
                vif.i_tvalid = 1'b0;
                #1;
            end
            if (vif.o_tvalid) begin
                ocnt++;
                check("rst_mid_data", 64'(vif.o_tdata), 64'hDEAD_BEEF);
            end
            @(negedge clk);
        end
        check("rst_mid_outs", 64'(ocnt), 64'd3);
        reset = 1'b1;
        #1;
        check("rst_mid_i_tready", 64'(vif.i_tready), 64'd0);
        @(negedge clk);
        #1;
        check("rst_mid_o_tvalid", 64'(vif.o_tvalid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_exit_i_tready", 64'(vif.i_tready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("rst_no_stale", 64'(vif.o_tvalid), 64'd0);
        end
        @(negedge clk);
        n = 16'd2;
        inq = '{{1'b1, 32'h0000_00EE}};
        expq = '{{1'b0, 32'h0000_00EE}, {1'b1, 32'h0000_00EE}};
        run(50, 1'b0, 0, '0);
        compare_out("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/repeat_each_n.md
# repeat_each_n

Interpolating counterpart of the sample decimator in the RFNoC QPSK datapath: every accepted AXI-Stream input beat is emitted `n` times on the output, either held (sample-and-hold) or zero-stuffed. Packet boundaries are preserved, and `n` and mode are sampled only at packet starts, so runtime reconfiguration never splits a packet. The block sits between the symbol mapper and the pulse-shaping filter.

## Interface
- `WIDTH`, 32, sample width in bits
- `MAX_N`, 65535, largest repetition factor; `CW = $clog2(MAX_N+1)`
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: synchronous, active-high
- `n` in CW: repetition factor; 0 treated as 1 (pass-through)
- `zero_stuff` in 1: 0 = hold (repeat data), 1 = data on first repetition, zeros after
- `i_tdata` in WIDTH, `i_tlast` in 1, `i_tvalid` in 1, `i_tready` out 1: input stream
- `o_tdata` out WIDTH, `o_tlast` out 1, `o_tvalid` out 1, `o_tready` in 1: output stream

## Operation
- Registers: `data_reg` (WIDTH), `last_reg`, `rep_cnt` (CW, 1-based), `n_cur` (CW), `zs_cur`, `sop`, `o_tvalid`.
- FSM: IDLE (`o_tvalid`=0) and ACTIVE (`o_tvalid`=1). `last_rep = (rep_cnt == n_cur)`.
- `i_tready = ~reset & (IDLE | (o_tready & last_rep))`.
- Input accept (`i_tvalid & i_tready`):
  - `data_reg<=i_tdata`, `last_reg<=i_tlast`, `rep_cnt<=1`; go to ACTIVE.
  - If `sop`: `n_cur <= (n==0) ? 1 : n`, `zs_cur <= zero_stuff`. Otherwise both hold.
  - `sop <= i_tlast`.
- Output transfer (`o_tvalid & o_tready`):
  - Not `last_rep`: `rep_cnt++`.
  - `last_rep` with no simultaneous accept: go to IDLE.
  - `last_rep` with simultaneous accept: stay ACTIVE and load the new beat, with no bubble.
- `o_tdata = (zs_cur & rep_cnt != 1) ? 0 : data_reg`.
- `o_tlast = last_reg & last_rep`. tlast appears only on the final repetition of an input beat that carried `i_tlast`.
- `o_tdata`, `o_tlast` and `o_tvalid` are stable while `o_tvalid & ~o_tready`.
- `rep_cnt` never exceeds `n_cur`, so no wrap-around is possible. `n_cur` is at least 1.

## Timing
- Reset values:
  - `o_tvalid`=0, `o_tdata`=0, `o_tlast`=0.
  - `i_tready`=0 during reset and 1 on the first cycle after.
  - `sop`=1, `n_cur`=1, `zs_cur`=0, `rep_cnt`=1.
- Latency: an input accepted in cycle t appears as `o_tvalid`=1 in cycle t+1.
- Throughput: with `o_tready` held at 1, exactly one output beat per cycle. The input is accepted once every `n_cur` cycles, back-to-back.
- Changing `n` or `zero_stuff` mid-packet has no effect until the first beat after an `i_tlast` beat.
- Reset mid-repetition discards remaining repetitions immediately. The next packet uses the then-current `n`.
- Pass-through (`n_cur`=1): `i_tready = ~o_tvalid | o_tready`, which makes the block a full-rate one-stage register.

## Structure
- Package `repeat_each_n_pkg`:
  - state enum `{IDLE, ACTIVE}`
  - function `cnt_width(max_n)` returning `$clog2(max_n+1)`
- Single module, no sub-modules; the output register is integral to the repeat counter.

## Test plan
- **Hold, n=3:** send A, B (tlast on B), `o_tready`=1 → output A,A,A,B,B,B; tlast only on the 6th beat; `i_tready` high on cycles 0, 3 and 6 after reset.
- **Zero-stuff, n=4:** send 0x1234, 0x5678 (tlast) → 0x1234,0,0,0,0x5678,0,0,0; tlast on the 8th beat.
- **n=0 pass-through:** 16 beats at full rate with `o_tready`=1 → 16 identical outputs, one cycle latency, no bubbles.
- **Backpressure, n=2:** random `o_tready` (50%) over 100 input beats → 200 output beats in order; every held beat is stable while stalled.
- **Mid-packet change:** packet of 3 beats at n=2; set n=5 after beat 1 → that packet yields 6 outputs; the next packet repeats ×5.
- **Reset mid-repetition:** n=8, assert reset after the 3rd output → `o_tvalid`=0 the next cycle, no stale beats afterwards, `i_tready`=1 one cycle after reset deasserts.
